// File: rtl/count_compare.sv
// Pairs samples from a reference-counter stream (a) and an observed-counter stream (b),
// compares each pair bitwise and keeps match/mismatch statistics over NUM_TESTS pairs per run.
module count_compare #(
  parameter int NUM_TESTS = 100,
  parameter int WIDTH     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [WIDTH-1:0] b_data,
  output logic [15:0]      match_cnt,
  output logic [15:0]      mismatch_cnt,
  output logic             error,
  output logic [15:0]      first_err_idx,
  output logic             done,
  output logic [1:0]       o_dbg_state
);

  // Handshake: a word moves on a rising edge where valid and ready are both 1;
  // ready never depends on valid, and a source keeps valid/data stable until taken.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [16:0] LP_NUM = 17'(NUM_TESTS);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_a_full;
  logic             r_b_full;
  logic [WIDTH-1:0] r_a_data;
  logic [WIDTH-1:0] r_b_data;
  logic [15:0]      r_idx;
  logic [15:0]      r_match_cnt;
  logic [15:0]      r_mismatch_cnt;
  logic             r_error;
  logic [15:0]      r_first_err_idx;
  logic             r_done;

  logic             w_run;
  logic             w_pair_fire;
  logic             w_a_ready;
  logic             w_b_ready;
  logic             w_a_acc;
  logic             w_b_acc;
  logic             w_start_run;
  logic             w_equal;
  logic [16:0]      w_idx_inc;
  logic             w_last;

  assign w_run       = (r_state == ST_RUN);
  assign w_pair_fire = w_run & r_a_full & r_b_full;
  // A holding slot may reload in the same cycle its pair is consumed.
  assign w_a_ready   = w_run & (~r_a_full | w_pair_fire);
  assign w_b_ready   = w_run & (~r_b_full | w_pair_fire);
  assign w_a_acc     = a_valid & w_a_ready;
  assign w_b_acc     = b_valid & w_b_ready;
  assign w_start_run = start & (r_state != ST_RUN);
  assign w_equal     = (r_a_data == r_b_data);
  assign w_idx_inc   = {1'b0, r_idx} + 17'd1;
  assign w_last      = (w_idx_inc == LP_NUM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_pair_fire && w_last) w_state_nxt = ST_DONE;
      ST_DONE: if (start) w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_full        <= 1'b0;
      r_b_full        <= 1'b0;
      r_a_data        <= '0;
      r_b_data        <= '0;
      r_idx           <= '0;
      r_match_cnt     <= '0;
      r_mismatch_cnt  <= '0;
      r_error         <= 1'b0;
      r_first_err_idx <= '0;
      r_done          <= 1'b0;
    end else if (w_start_run) begin
      r_a_full        <= 1'b0;
      r_b_full        <= 1'b0;
      r_idx           <= '0;
      r_match_cnt     <= '0;
      r_mismatch_cnt  <= '0;
      r_error         <= 1'b0;
      r_first_err_idx <= '0;
      r_done          <= 1'b0;
    end else begin
      if (w_a_acc) begin
        r_a_full <= 1'b1;
        r_a_data <= a_data;
      end else if (w_pair_fire) begin
        r_a_full <= 1'b0;
      end
      if (w_b_acc) begin
        r_b_full <= 1'b1;
        r_b_data <= b_data;
      end else if (w_pair_fire) begin
        r_b_full <= 1'b0;
      end
      if (w_pair_fire) begin
        r_idx <= w_idx_inc[15:0];
        if (w_equal) begin
          if (r_match_cnt != 16'hFFFF) r_match_cnt <= r_match_cnt + 16'd1;
        end else begin
          if (r_mismatch_cnt != 16'hFFFF) r_mismatch_cnt <= r_mismatch_cnt + 16'd1;
          // Only the first mismatch of a run records its index.
          if (!r_error) begin
            r_error         <= 1'b1;
            r_first_err_idx <= r_idx;
          end
        end
        if (w_last) r_done <= 1'b1;
      end
    end
  end

  assign a_ready       = w_a_ready;
  assign b_ready       = w_b_ready;
  assign match_cnt     = r_match_cnt;
  assign mismatch_cnt  = r_mismatch_cnt;
  assign error         = r_error;
  assign first_err_idx = r_first_err_idx;
  assign done          = r_done;
  // 0 = IDLE, 1 = RUN, 2 = DONE
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_count_compare.sv
// Randomized bench for count_compare: two instances (100 and 300 pairs per run) checked each
// cycle against a model that pairs the k-th accepted a word with the k-th accepted b word.
module tb_count_compare;

  localparam int W    = 8;
  localparam int N0   = 100;
  localparam int N1   = 300;
  localparam int HMAX = 512;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         start[2], a_valid[2], b_valid[2], a_ready[2], b_ready[2], error[2], done[2];
  logic [W-1:0] a_data[2], b_data[2];
  logic [15:0]  match_cnt[2], mismatch_cnt[2], first_err_idx[2];
  logic [1:0]   dbg_state[2];

  count_compare #(.NUM_TESTS(N0), .WIDTH(W)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]),
    .a_valid(a_valid[0]), .a_ready(a_ready[0]), .a_data(a_data[0]),
    .b_valid(b_valid[0]), .b_ready(b_ready[0]), .b_data(b_data[0]),
    .match_cnt(match_cnt[0]), .mismatch_cnt(mismatch_cnt[0]), .error(error[0]),
    .first_err_idx(first_err_idx[0]), .done(done[0]), .o_dbg_state(dbg_state[0])
  );

  count_compare #(.NUM_TESTS(N1), .WIDTH(W)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]),
    .a_valid(a_valid[1]), .a_ready(a_ready[1]), .a_data(a_data[1]),
    .b_valid(b_valid[1]), .b_ready(b_ready[1]), .b_data(b_data[1]),
    .match_cnt(match_cnt[1]), .mismatch_cnt(mismatch_cnt[1]), .error(error[1]),
    .first_err_idx(first_err_idx[1]), .done(done[1]), .o_dbg_state(dbg_state[1])
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Stimulus sources
  logic [W-1:0] src_a[2][HMAX], src_b[2][HMAX];
  int src_len[2], pos_a[2], pos_b[2], pct_a[2], pct_b[2];

  // Reference model: accepted-word histories and run statistics
  logic [W-1:0] hist_a[2][HMAX], hist_b[2][HMAX];
  int na[2], nb[2], m_pairs[2], m_match[2], m_mis[2], m_first[2], run_cyc[2], done_cyc[2];
  bit m_err[2], m_run[2], m_done[2];
  int num_tests[2];

  bit           acc_a[2], acc_b[2], start_drv[2], start_req[2];
  logic [W-1:0] acc_da[2], acc_db[2];

  task automatic model_clear(input int d);
    na[d] = 0; nb[d] = 0; m_pairs[d] = 0; m_match[d] = 0; m_mis[d] = 0; m_first[d] = 0;
    m_err[d] = 0; m_done[d] = 0; run_cyc[d] = 0; done_cyc[d] = -1;
  endtask

  task automatic model_update(input int d);
    int avail;
    if (start_drv[d] && !m_run[d]) begin
      model_clear(d);
      m_run[d] = 1;
    end else if (m_run[d]) begin
      run_cyc[d]++;
      avail = (na[d] < nb[d]) ? na[d] : nb[d];
      while (m_run[d] && m_pairs[d] < avail) begin
        if (hist_a[d][m_pairs[d]] == hist_b[d][m_pairs[d]]) begin
          if (m_match[d] < 65535) m_match[d]++;
        end else begin
          if (m_mis[d] < 65535) m_mis[d]++;
          if (!m_err[d]) begin
            m_err[d]   = 1;
            m_first[d] = m_pairs[d];
          end
        end
        m_pairs[d]++;
        if (m_pairs[d] == num_tests[d]) begin
          m_run[d]    = 0;
          m_done[d]   = 1;
          done_cyc[d] = run_cyc[d];
        end
      end
      if (acc_a[d] && na[d] < HMAX) begin hist_a[d][na[d]] = acc_da[d]; na[d]++; end
      if (acc_b[d] && nb[d] < HMAX) begin hist_b[d][nb[d]] = acc_db[d]; nb[d]++; end
    end
  endtask

  task automatic check_outputs(input int d);
    bit held_a, held_b;
    int exp_state;
    held_a    = na[d] > m_pairs[d];
    held_b    = nb[d] > m_pairs[d];
    exp_state = m_run[d] ? 1 : (m_done[d] ? 2 : 0);
    check_eq($sformatf("d%0d_match", d),     int'(match_cnt[d]),     m_match[d]);
    check_eq($sformatf("d%0d_mismatch", d),  int'(mismatch_cnt[d]),  m_mis[d]);
    check_eq($sformatf("d%0d_error", d),     int'(error[d]),         int'(m_err[d]));
    check_eq($sformatf("d%0d_first_idx", d), int'(first_err_idx[d]), m_first[d]);
    check_eq($sformatf("d%0d_done", d),      int'(done[d]),          int'(m_done[d]));
    check_eq($sformatf("d%0d_a_ready", d),   int'(a_ready[d]),       int'(m_run[d] && (!held_a || held_b)));
    check_eq($sformatf("d%0d_b_ready", d),   int'(b_ready[d]),       int'(m_run[d] && (!held_b || held_a)));
    check_eq($sformatf("d%0d_state", d),     int'(dbg_state[d]),     exp_state);
  endtask

  task automatic drive(input int d);
    if (acc_a[d]) pos_a[d]++;
    if (acc_b[d]) pos_b[d]++;
    if (!a_valid[d] || acc_a[d]) begin
      if (pos_a[d] < src_len[d] && int'($urandom_range(0, 99)) < pct_a[d]) begin
        a_valid[d] = 1'b1; a_data[d] = src_a[d][pos_a[d]];
      end else begin
        a_valid[d] = 1'b0; a_data[d] = W'($urandom);
      end
    end
    if (!b_valid[d] || acc_b[d]) begin
      if (pos_b[d] < src_len[d] && int'($urandom_range(0, 99)) < pct_b[d]) begin
        b_valid[d] = 1'b1; b_data[d] = src_b[d][pos_b[d]];
      end else begin
        b_valid[d] = 1'b0; b_data[d] = W'($urandom);
      end
    end
    start[d]     = start_req[d];
    start_drv[d] = start_req[d];
    start_req[d] = 0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      model_update(d);
      check_outputs(d);
      drive(d);
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      acc_a[d]  = a_valid[d] & a_ready[d];
      acc_b[d]  = b_valid[d] & b_ready[d];
      acc_da[d] = a_data[d];
      acc_db[d] = b_data[d];
    end
  endtask

  // kind 0: counter values i mod 2^W; kind 1: random equal; kind 2: random with ~8% corrupted b
  task automatic load(input int d, input int n, input int kind, input int pa, input int pb);
    logic [W-1:0] v;
    for (int i = 0; i < n; i++) begin
      v = (kind == 0) ? W'(i) : W'($urandom);
      src_a[d][i] = v;
      src_b[d][i] = (kind == 2 && $urandom_range(0, 99) < 8) ? (v ^ W'($urandom_range(1, 255))) : v;
    end
    src_len[d] = n; pos_a[d] = 0; pos_b[d] = 0; pct_a[d] = pa; pct_b[d] = pb;
  endtask

  task automatic pulse_start(input int d);
    start_req[d] = 1;
    step();
    step();
  endtask

  task automatic run_done(input int d, input int budget, input string tag);
    int k;
    k = 0;
    while (!m_done[d] && k < budget) begin
      step();
      k++;
    end
    if (!m_done[d]) check_eq({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_pairs(input int d, input int n, input string tag);
    int k;
    k = 0;
    while (m_pairs[d] < n && k < 1000) begin
      step();
      k++;
    end
    if (m_pairs[d] < n) check_eq({tag, "_pairs_timeout"}, m_pairs[d], n);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      a_valid[d] = 1'b0; b_valid[d] = 1'b0; start[d] = 1'b0;
      start_req[d] = 0; start_drv[d] = 0; acc_a[d] = 0; acc_b[d] = 0;
      src_len[d] = 0; pos_a[d] = 0; pos_b[d] = 0;
      m_run[d] = 0;
      model_clear(d);
    end
    #1;
    for (int d = 0; d < 2; d++) check_outputs(d);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    num_tests[0] = N0;
    num_tests[1] = N1;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      a_valid[d] = 1'b0; b_valid[d] = 1'b0; start[d] = 1'b0;
      a_data[d] = '0; b_data[d] = '0;
      start_req[d] = 0; start_drv[d] = 0; acc_a[d] = 0; acc_b[d] = 0;
      acc_da[d] = '0; acc_db[d] = '0;
      src_len[d] = 0; pos_a[d] = 0; pos_b[d] = 0; pct_a[d] = 0; pct_b[d] = 0;
      m_run[d] = 0;
      model_clear(d);
    end
    #3;
    for (int d = 0; d < 2; d++) check_outputs(d);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Valid offered without a start must not be taken
    load(0, N0, 0, 100, 100);
    repeat (4) step();
    check_eq("nostart_a_ready", int'(a_ready[0]), 0);

    // Back-to-back identical streams: one pair per cycle
    pulse_start(0);
    run_done(0, 400, "t1");
    check_eq("t1_match", int'(match_cnt[0]), 100);
    check_eq("t1_mismatch", int'(mismatch_cnt[0]), 0);
    check_eq("t1_error", int'(error[0]), 0);
    check_eq("t1_done_latency", done_cyc[0], N0 + 1);
    step();
    check_eq("t1_done_hold", int'(done[0]), 1);

    // Two corrupted b samples at pairs 42 and 60
    load(0, N0, 0, 70, 60);
    src_b[0][42] = 8'd43;
    src_b[0][60] = 8'd61;
    pulse_start(0);
    run_done(0, 1000, "t2");
    check_eq("t2_match", int'(match_cnt[0]), 98);
    check_eq("t2_mismatch", int'(mismatch_cnt[0]), 2);
    check_eq("t2_error", int'(error[0]), 1);
    check_eq("t2_first_idx", int'(first_err_idx[0]), 42);

    // a runs ahead while b stays idle
    load(0, N0, 0, 100, 0);
    pulse_start(0);
    repeat (5) step();
    check_eq("t3_a_ready_blocked", int'(a_ready[0]), 0);
    check_eq("t3_b_ready", int'(b_ready[0]), 1);
    check_eq("t3_match_wait", int'(match_cnt[0]), 0);
    pct_b[0] = 100;
    repeat (3) step();
    check_eq("t3_match_one", int'(match_cnt[0]), 1);
    run_done(0, 400, "t3");
    check_eq("t3_match", int'(match_cnt[0]), 100);

    // Reset in the middle of a run with a held and b empty
    load(0, N0, 0, 100, 100);
    pulse_start(0);
    wait_pairs(0, 50, "t4");
    pct_b[0] = 0;
    repeat (3) step();
    check_eq("t4_a_held_blocked", int'(a_ready[0]), 0);
    do_reset();
    check_eq("t4_rst_match", int'(match_cnt[0]), 0);
    check_eq("t4_rst_state", int'(dbg_state[0]), 0);
    load(0, N0, 0, 100, 100);
    repeat (3) step();
    pulse_start(0);
    run_done(0, 400, "t4");
    check_eq("t4_match", int'(match_cnt[0]), 100);
    check_eq("t4_error", int'(error[0]), 0);

    // start inside RUN is ignored; start in DONE re-runs cleanly
    load(0, N0, 0, 80, 80);
    pulse_start(0);
    wait_pairs(0, 10, "t5");
    start_req[0] = 1;
    step();
    step();
    run_done(0, 1000, "t5a");
    check_eq("t5a_match", int'(match_cnt[0]), 100);
    check_eq("t5a_mismatch", int'(mismatch_cnt[0]), 0);
    load(0, N0, 0, 80, 80);
    pulse_start(0);
    check_eq("t5_cleared", int'(match_cnt[0]), 0);
    check_eq("t5_done_cleared", int'(done[0]), 0);
    run_done(0, 1000, "t5b");
    check_eq("t5b_match", int'(match_cnt[0]), 100);
    check_eq("t5b_mismatch", int'(mismatch_cnt[0]), 0);

    // Random data, random gaps, random corruptions
    for (int r = 0; r < 3; r++) begin
      load(0, N0, (r == 0) ? 1 : 2, $urandom_range(30, 100), $urandom_range(30, 100));
      pulse_start(0);
      run_done(0, 2000, "trand");
    end

    // 300 counter samples wrapping 255 -> 0
    load(1, N1, 0, 90, 90);
    pulse_start(1);
    run_done(1, 2000, "t6");
    check_eq("t6_match", int'(match_cnt[1]), 300);
    check_eq("t6_error", int'(error[1]), 0);
    check_eq("t6_done", int'(done[1]), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/count_compare.md
COUNT_COMPARE -- requirements
Module: count_compare

Interface
REQ-001 SHALL have parameter NUM_TESTS, default 100, number of sample pairs per run (1..65535).
REQ-002 SHALL have parameter WIDTH, default 8, width of each count sample.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, one-cycle pulse that begins a run.
REQ-007 SHALL have ports a_valid/a_ready/a_data, input/output/input, 1/1/WIDTH, forming the reference-counter stream.
REQ-008 SHALL have ports b_valid/b_ready/b_data, input/output/input, 1/1/WIDTH, forming the observed-counter stream.
REQ-009 SHALL have port match_cnt, output, 16, number of equal pairs in the current run.
REQ-010 SHALL have port mismatch_cnt, output, 16, number of unequal pairs in the current run.
REQ-011 SHALL have port error, output, 1, sticky flag, set on the first mismatch of a run.
REQ-012 SHALL have port first_err_idx, output, 16, pair index (0-based) of the first mismatch.
REQ-013 SHALL have port done, output, 1, high when NUM_TESTS pairs have been compared.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 SHALL go IDLE->RUN and DONE->RUN on start=1; start SHALL be ignored in RUN.
REQ-016 SHALL, on entering RUN, clear match_cnt, mismatch_cnt, error, first_err_idx, pair index, holding flags, and done in the same edge.
REQ-017 SHALL hold each stream in a one-entry register (a_full/b_full); transfer occurs when valid and ready are both 1 at a rising edge.
REQ-018 SHALL drive a_ready = RUN and (not a_full or pair_fire), where pair_fire = a_full and b_full; b_ready is defined the same way with b_full.
REQ-019 SHALL, in every cycle with pair_fire=1, compare the held values bitwise over WIDTH bits and update the counters at that cycle's ending edge.
REQ-020 SHALL treat that update as 1 cycle of latency: counters reflect a pair on the edge after the later of its two accepts.
REQ-021 SHALL, on pair_fire with a new accept in the same cycle, both consume the held entry and load the new entry, sustaining one pair per cycle.
REQ-022 SHALL, on mismatch when error=0, set error and latch first_err_idx = current pair index; later mismatches SHALL NOT change first_err_idx.
REQ-023 SHALL move RUN->DONE on the edge where pair index reaches NUM_TESTS; done=1 and both readies 0 from then on.
REQ-024 SHALL keep the DONE counters and flags stable until the next start.
REQ-025 SHALL let one stream run ahead by at most one entry; the leading stream is back-pressured (ready=0) until the other catches up.
REQ-026 SHALL saturate match_cnt and mismatch_cnt at 16'hFFFF rather than wrap.
REQ-027 SHALL keep a_ready/b_ready at 0 in IDLE and DONE; valid in those states SHALL NOT be consumed.

Reset
REQ-028 SHALL, on rst_n=0, immediately force IDLE, all counters 0, error=0, first_err_idx=0, done=0, a_ready=b_ready=0, holding flags empty.
REQ-029 SHALL, on reset asserted mid-RUN, discard any partially held pair; no counter update from it.
REQ-030 SHALL require a start pulse after reset deassertion before any transfer.

Verification
REQ-031 SHALL cover: NUM_TESTS=100, start, both streams send 0..99 every cycle -> done after 100 pairs, match_cnt=100, mismatch_cnt=0, error=0, one pair per cycle throughput.
REQ-032 SHALL cover: b stream sends value 42 as 43 at pair 42, and 60 as 61 at pair 60 -> mismatch_cnt=2, match_cnt=98, error=1, first_err_idx=42.
REQ-033 SHALL cover: a_valid held high while b_valid is idle for 5 cycles -> a_ready=0 after one accept, no counter change until b arrives, then match_cnt increments by 1.
REQ-034 SHALL cover: rst_n pulsed low at pair 50 with a held and b empty -> all outputs 0, state IDLE; a fresh start gives a clean run with match_cnt=100.
REQ-035 SHALL cover: start pulsed in RUN at pair 10 -> no effect, run completes; start in DONE -> counters cleared and second run completes identically.
REQ-036 SHALL cover: WIDTH=8 stream wraps 255->0 with NUM_TESTS=300 on both streams -> match_cnt=300, error=0.
